spi_mst_xfer: RTL and testbench



---
 rtl/spi_mst_xfer.sv | 156 +++++++++++++++
 tb/tb_spi_mst_xfer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mst_xfer.sv
// SPI master transfer engine: valid/ready frame interface in, SCL/CS/MOSI out,
// MISO sampled into an rx strobe. All four CPOL/CPHA modes, MSB first.
module spi_mst_xfer #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              spi_scl,
  output logic              spi_cs,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GUARD} state_t;

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  state_t              state;
  logic                cpol_q;
  logic                cpha_q;
  logic                last_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    div_cnt;
  logic [EDGE_W-1:0]   edge_cnt;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;

  logic                accept;
  logic                tick;
  logic                edge_now;
  logic [EDGE_W-1:0]   edge_nxt;
  logic                leading;
  logic                sample_now;
  logic                drive_now;
  logic                frame_end;
  logic                acc_cpha;
  logic [DATA_W-1:0]   rx_next;

  assign tx_ready = (state == IDLE) || (state == WAIT);
  assign busy     = (state != IDLE);
  assign accept   = tx_valid && tx_ready;

  // Compare-based divider: the counter never exceeds div_q, so all-ones needs no extra bit.
  assign tick     = (div_cnt == div_q);
  assign edge_now = tick && ((state == SETUP) || (state == SHIFT));
  assign edge_nxt = edge_cnt + 1'b1;
  assign leading  = edge_nxt[0];

  // CPHA=0 samples on leading edges, CPHA=1 on trailing ones.
  assign sample_now = edge_now && (leading ^ cpha_q);
  assign drive_now  = edge_now && (cpha_q ? leading : (!leading && (edge_nxt != LAST_EDGE)));
  assign frame_end  = edge_now && (edge_nxt == LAST_EDGE);
  assign rx_next    = sample_now ? {rx_sh[DATA_W-2:0], spi_miso} : rx_sh;

  // A burst re-accept in WAIT keeps the mode latched at the first accept.
  assign acc_cpha = (state == IDLE) ? cpha : cpha_q;

  // NOTE: every register here uses non-blocking assignment so all updates in a
  // cycle see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      spi_cs   <= 1'b1;
      spi_scl  <= 1'b0;
      spi_mosi <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      last_q   <= 1'b0;
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else begin
      rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          spi_scl <= cpol;
          if (accept) begin
            cpol_q <= cpol;
            cpha_q <= cpha;
            div_q  <= clk_div;
          end
        end

        SETUP, SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (edge_now) begin
            spi_scl  <= ~spi_scl;
            edge_cnt <= edge_nxt;
            rx_sh    <= rx_next;
            state    <= SHIFT;
            if (drive_now) begin
              spi_mosi <= tx_sh[DATA_W-1];
              tx_sh    <= tx_sh << 1;
            end
            if (frame_end) begin
              rx_valid <= 1'b1;
              rx_data  <= rx_next;
              edge_cnt <= '0;
              state    <= last_q ? HOLD : WAIT;
            end
          end
        end

        WAIT: ;

        HOLD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) begin
            spi_cs <= 1'b1;
            state  <= GUARD;
          end
        end

        GUARD: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (tick) state <= IDLE;
        end

        default: state <= IDLE;
      endcase

      // Frame load is shared by the IDLE and WAIT accept paths.
      if (accept) begin
        state    <= SETUP;
        spi_cs   <= 1'b0;
        last_q   <= tx_last;
        div_cnt  <= '0;
        edge_cnt <= '0;
        if (acc_cpha) begin
          tx_sh <= tx_data;
        end else begin
          spi_mosi <= tx_data[DATA_W-1];
          tx_sh    <= tx_data << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_mst_xfer.sv
// Directed bench for spi_mst_xfer: mode-aware slave model, event monitor with
// cycle timestamps, and hand-computed timing/data expectations.
module tb_spi_mst_xfer;

  localparam int DATA_W = 8;
  localparam int DIV_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic [DIV_W-1:0]  clk_div = '0;
  logic              tx_valid = 1'b0;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_last = 1'b0;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              spi_scl;
  logic              spi_cs;
  logic              spi_mosi;
  logic              spi_miso = 1'b0;

  spi_mst_xfer #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpol     (cpol),
    .cpha     (cpha),
    .clk_div  (clk_div),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .spi_scl  (spi_scl),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  // Event monitor: cycle stamps of SCL edges (while CS low), CS edges, rx strobes, tx_ready rises.
  int   scl_q[$], csf_q[$], csr_q[$], rxt_q[$], rxd_q[$], rdy_q[$];
  logic m_scl = 1'b0, m_cs = 1'b1, m_rdy = 1'b0;

  always @(negedge clk) begin
    if (spi_scl !== m_scl && spi_cs == 1'b0) scl_q.push_back(cyc);
    if (m_cs && !spi_cs) csf_q.push_back(cyc);
    if (!m_cs && spi_cs) csr_q.push_back(cyc);
    if (rx_valid) begin
      rxt_q.push_back(cyc);
      rxd_q.push_back(int'(rx_data));
    end
    if (tx_ready && !m_rdy) rdy_q.push_back(cyc);
    m_scl <= spi_scl;
    m_cs  <= spi_cs;
    m_rdy <= tx_ready;
  end

  // Slave model: drives s_words[frame] on MISO and records MOSI, per configured mode.
  logic        s_cpol = 1'b0;
  logic        s_cpha = 1'b0;
  logic [7:0]  s_words [4];
  logic        sl_prev_scl = 1'b0;
  logic        sl_prev_cs = 1'b1;
  int          sl_edge = 0;
  int          sl_fi = 0;
  logic [7:0]  sl_tsh = '0;
  logic [7:0]  sl_rsh = '0;
  int          sl_rx_q[$];

  always @(negedge clk) begin
    sl_prev_scl <= spi_scl;
    sl_prev_cs  <= spi_cs;
    if (sl_prev_cs && !spi_cs) begin
      sl_edge <= 0;
      sl_fi   <= 0;
      if (!s_cpha) begin
        spi_miso <= s_words[0][7];
        sl_tsh   <= s_words[0] << 1;
      end else begin
        sl_tsh <= s_words[0];
      end
    end else if (!spi_cs && spi_scl != sl_prev_scl) begin
      sl_edge <= (sl_edge + 1 == 2 * DATA_W) ? 0 : sl_edge + 1;
      if (spi_scl != s_cpol) begin
        if (!s_cpha) begin
          sl_rsh <= {sl_rsh[6:0], spi_mosi};
        end else begin
          spi_miso <= sl_tsh[7];
          sl_tsh   <= sl_tsh << 1;
        end
      end else if (!s_cpha) begin
        if (sl_edge + 1 == 2 * DATA_W) begin
          sl_rx_q.push_back(int'(sl_rsh));
          sl_fi    <= sl_fi + 1;
          spi_miso <= s_words[(sl_fi + 1) % 4][7];
          sl_tsh   <= s_words[(sl_fi + 1) % 4] << 1;
        end else begin
          spi_miso <= sl_tsh[7];
          sl_tsh   <= sl_tsh << 1;
        end
      end else begin
        sl_rsh <= {sl_rsh[6:0], spi_mosi};
        if (sl_edge + 1 == 2 * DATA_W) begin
          sl_rx_q.push_back(int'({sl_rsh[6:0], spi_mosi}));
          sl_fi  <= sl_fi + 1;
          sl_tsh <= s_words[(sl_fi + 1) % 4];
        end
      end
    end
  end

  // Called at a negedge; returns the accept cycle T (tx_valid&tx_ready sampled at end of T).
  task automatic send(input logic [7:0] d, input logic last, output int t);
    tx_data  = d;
    tx_last  = last;
    tx_valid = 1'b1;
    t = -1;
    for (int i = 0; i < 400; i++) begin
      if (tx_ready) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_edges(input string tag, input int e0, input int t, input int h);
    int bad;
    bad = 0;
    check({tag, "_nedges"}, 32'(scl_q.size() - e0), 32'd16);
    for (int k = 1; k <= 16; k++)
      if (at(scl_q, e0 + k - 1) != t + 1 + k * h) bad++;
    check({tag, "_edge_times"}, 32'(bad), 32'd0);
  endtask

  int t0, t1, t2, e0, cf0, cr0, r0, ry0, s0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) s_words[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(spi_cs), 32'd1);
    check("rst_scl", 32'(spi_scl), 32'd0);
    check("rst_mosi", 32'(spi_mosi), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    repeat (2) @(negedge clk);

    // Mode 0, H=2: 0xA5 out, 0x3C back
    cpol = 0; cpha = 0; clk_div = 8'd1;
    s_cpol = 0; s_cpha = 0; s_words[0] = 8'h3C;
    repeat (2) @(negedge clk);
    e0 = scl_q.size(); cf0 = csf_q.size(); cr0 = csr_q.size();
    r0 = rxt_q.size(); ry0 = rdy_q.size(); s0 = sl_rx_q.size();
    send(8'hA5, 1'b1, t0);
    wait_idle("m0");
    check("m0_cs_fall", 32'(at(csf_q, cf0)), 32'(t0 + 1));
    check_edges("m0", e0, t0, 2);
    check("m0_rx_time", 32'(at(rxt_q, r0)), 32'(t0 + 33));
    check("m0_rx_count", 32'(rxt_q.size() - r0), 32'd1);
    check("m0_rx_data", 32'(at(rxd_q, r0)), 32'h3C);
    check("m0_cs_rise", 32'(at(csr_q, cr0)), 32'(t0 + 35));
    check("m0_ready_rise", 32'(at(rdy_q, ry0)), 32'(t0 + 37));
    check("m0_mosi_word", 32'(at(sl_rx_q, s0)), 32'hA5);

    // Modes 1..3, H=1: 0x81 through a loopback-pattern slave
    for (int m = 1; m < 4; m++) begin
      cpol = m[1]; cpha = m[0]; clk_div = 8'd0;
      s_cpol = m[1]; s_cpha = m[0]; s_words[0] = 8'h81;
      repeat (3) @(negedge clk);
      check($sformatf("mode%0d_scl_idle", m), 32'(spi_scl), 32'(m[1]));
      e0 = scl_q.size(); r0 = rxd_q.size(); s0 = sl_rx_q.size();
      send(8'h81, 1'b1, t0);
      wait_idle($sformatf("mode%0d", m));
      check_edges($sformatf("mode%0d", m), e0, t0, 1);
      check($sformatf("mode%0d_rx_data", m), 32'(at(rxd_q, r0)), 32'h81);
      check($sformatf("mode%0d_mosi_word", m), 32'(at(sl_rx_q, s0)), 32'h81);
      check($sformatf("mode%0d_scl_after", m), 32'(spi_scl), 32'(m[1]));
    end

    // Burst of three frames, CS held low
    cpol = 0; cpha = 0; clk_div = 8'd1;
    s_cpol = 0; s_cpha = 0;
    s_words[0] = 8'hC1; s_words[1] = 8'hC2; s_words[2] = 8'hC3;
    repeat (3) @(negedge clk);
    cf0 = csf_q.size(); cr0 = csr_q.size(); r0 = rxt_q.size(); s0 = sl_rx_q.size();
    send(8'h11, 1'b0, t0);
    send(8'h22, 1'b0, t1);
    send(8'h33, 1'b1, t2);
    wait_idle("burst");
    check("burst_cs_falls", 32'(csf_q.size() - cf0), 32'd1);
    check("burst_cs_rises", 32'(csr_q.size() - cr0), 32'd1);
    check("burst_rx_count", 32'(rxt_q.size() - r0), 32'd3);
    check("burst_rx0", 32'(at(rxd_q, r0)), 32'hC1);
    check("burst_rx1", 32'(at(rxd_q, r0 + 1)), 32'hC2);
    check("burst_rx2", 32'(at(rxd_q, r0 + 2)), 32'hC3);
    check("burst_reaccept", 32'(t1), 32'(t0 + 33));
    check("burst_cs_rise", 32'(at(csr_q, cr0)), 32'(at(rxt_q, r0 + 2) + 2));
    check("burst_mosi0", 32'(at(sl_rx_q, s0)), 32'h11);
    check("burst_mosi1", 32'(at(sl_rx_q, s0 + 1)), 32'h22);
    check("burst_mosi2", 32'(at(sl_rx_q, s0 + 2)), 32'h33);

    // Config change while busy: no effect until the next accept from IDLE
    s_words[0] = 8'h96;
    repeat (2) @(negedge clk);
    e0 = scl_q.size(); r0 = rxd_q.size(); s0 = sl_rx_q.size();
    send(8'h69, 1'b1, t0);
    while (cyc < t0 + 10) @(negedge clk);
    cpol = 1'b1; clk_div = 8'd7;
    wait_idle("cfg");
    check_edges("cfg", e0, t0, 2);
    check("cfg_rx_data", 32'(at(rxd_q, r0)), 32'h96);
    check("cfg_mosi_word", 32'(at(sl_rx_q, s0)), 32'h69);
    check("cfg_scl_new_idle", 32'(spi_scl), 32'd1);
    s_cpol = 1'b1; s_words[0] = 8'hA5;
    repeat (2) @(negedge clk);
    e0 = scl_q.size(); r0 = rxd_q.size(); s0 = sl_rx_q.size();
    send(8'h5A, 1'b1, t0);
    wait_idle("cfg2");
    check_edges("cfg2", e0, t0, 8);
    check("cfg2_rx_data", 32'(at(rxd_q, r0)), 32'hA5);
    check("cfg2_mosi_word", 32'(at(sl_rx_q, s0)), 32'h5A);

    // Reset at SCL edge 7
    cpol = 0; clk_div = 8'd1; s_cpol = 0; s_words[0] = 8'h0F;
    repeat (3) @(negedge clk);
    e0 = scl_q.size(); r0 = rxt_q.size();
    send(8'hC3, 1'b1, t0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (scl_q.size() - e0 >= 7) break;
    end
    check("rstm_at_edge7", 32'(scl_q.size() - e0), 32'd7);
    rst_n = 1'b0;
    #1;
    check("rstm_cs", 32'(spi_cs), 32'd1);
    check("rstm_scl", 32'(spi_scl), 32'd0);
    check("rstm_rx_valid", 32'(rx_valid), 32'd0);
    check("rstm_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstm_no_rx", 32'(rxt_q.size() - r0), 32'd0);
    check("rstm_rx_data", 32'(rx_data), 32'd0);
    s0 = sl_rx_q.size();
    send(8'hFF, 1'b1, t0);
    wait_idle("rstm");
    check("rstm_new_rx_count", 32'(rxt_q.size() - r0), 32'd1);
    check("rstm_new_rx_data", 32'(at(rxd_q, r0)), 32'h0F);
    check("rstm_new_mosi", 32'(at(sl_rx_q, s0)), 32'hFF);

    // Backpressure: request held through SHIFT and GUARD
    s_words[0] = 8'h3C;
    repeat (2) @(negedge clk);
    cf0 = csf_q.size(); r0 = rxd_q.size(); s0 = sl_rx_q.size();
    send(8'hE7, 1'b1, t0);
    while (cyc < t0 + 5) @(negedge clk);
    tx_data = 8'h18; tx_last = 1'b1; tx_valid = 1'b1;
    check("bp_ready_shift", 32'(tx_ready), 32'd0);
    while (cyc < t0 + 35) @(negedge clk);
    check("bp_ready_guard", 32'(tx_ready), 32'd0);
    check("bp_cs_guard", 32'(spi_cs), 32'd1);
    for (int i = 0; i < 100; i++) begin
      if (spi_cs == 1'b0) break;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    wait_idle("bp");
    check("bp_second_cs_fall", 32'(at(csf_q, cf0 + 1)), 32'(t0 + 38));
    check("bp_rx_count", 32'(rxd_q.size() - r0), 32'd2);
    check("bp_rx1", 32'(at(rxd_q, r0 + 1)), 32'h3C);
    check("bp_mosi0", 32'(at(sl_rx_q, s0)), 32'hE7);
    check("bp_mosi1", 32'(at(sl_rx_q, s0 + 1)), 32'h18);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
